// File: rtl/md_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings and latency defaults.
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // True for the four ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_start_op(logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply / divide datapath producing the 64-bit {hi, lo} result.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic        is_signed;
  logic        is_mult;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Divide on magnitudes then restore signs: avoids the 0x80000000 / -1 overflow trap and
  // gives truncation toward zero with the remainder following the dividend's sign.
  always_comb begin
    is_signed   = (op == MD_MULT) || (op == MD_DIV);
    is_mult     = (op == MD_MULT) || (op == MD_MULTU);
    a_ext       = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext       = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    prod        = a_ext * b_ext;
    div_by_zero = (b == 32'd0);
    a_neg       = is_signed & a[31];
    b_neg       = is_signed & b[31];
    a_mag       = a_neg ? (32'd0 - a) : a;
    // Substitute a harmless divisor on zero; the result is discarded by the caller.
    b_mag       = div_by_zero ? 32'd1 : (b_neg ? (32'd0 - b) : b);
    q_mag       = a_mag / b_mag;
    r_mag       = a_mag % b_mag;
    quot        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem         = a_neg ? (32'd0 - r_mag) : r_mag;
    result      = is_mult ? prod : {rem, quot};
  end

endmodule

// File: rtl/e_muldiv_unit.sv
// E-stage multi-cycle multiply/divide unit holding the architectural HI/LO registers.
module e_muldiv_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_hazard
);

  logic [63:0]      arith_res;
  logic             arith_dbz;

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  md_arith u_arith (
    .op          (md_op),
    .a           (rs_val),
    .b           (rt_val),
    .result      (arith_res),
    .div_by_zero (arith_dbz)
  );

  // Next-state: ops are only honoured while idle; a busy period ends with an optional commit.
  always_comb begin
    hi_d        = hi_q;
    lo_d        = lo_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d      = 1'b0;
        res_valid_d = 1'b0;
        if (res_valid_q) begin
          hi_d = res_hi_q;
          lo_d = res_lo_q;
        end
      end
    end else if (is_start_op(md_op)) begin
      res_hi_d = arith_res[63:32];
      res_lo_d = arith_res[31:0];
      busy_d   = 1'b1;
      if ((md_op == MD_MULT) || (md_op == MD_MULTU)) begin
        cnt_d       = CNT_W'(MULT_CYCLES);
        res_valid_d = 1'b1;
      end else begin
        cnt_d       = CNT_W'(DIV_CYCLES);
        res_valid_d = ~arith_dbz;
      end
    end else if (md_op == MD_MTHI) begin
      hi_d = rs_val;
    end else if (md_op == MD_MTLO) begin
      lo_d = rs_val;
    end
  end

  // State register with synchronous active-high reset; reset drops any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      res_hi_q    <= 32'd0;
      res_lo_q    <= 32'd0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  // Hazard covers the start cycle itself so a back-to-back md op in D stalls.
  always_comb begin
    hi        = hi_q;
    lo        = lo_q;
    busy      = busy_q;
    md_hazard = busy_q | is_start_op(md_op);
  end

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Self-checking bench for e_muldiv_unit: directed table, corner sequences, random vs. model.
module tb_e_muldiv_unit;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        md_hazard;

  int vectors = 0;
  int miscompares = 0;

  e_muldiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .md_hazard (md_hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  task automatic model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                       output logic [31:0] new_hi, output logic [31:0] new_lo,
                       output int cycles);
    longint          sp, sa, sb, q, r;
    longint unsigned up;
    new_hi = cur_hi;
    new_lo = cur_lo;
    cycles = 0;
    case (op)
      OP_MULT: begin
        sp = longint'($signed(rs)) * longint'($signed(rt));
        new_hi = sp[63:32]; new_lo = sp[31:0]; cycles = 5;
      end
      OP_MULTU: begin
        up = {32'd0, rs} * {32'd0, rt};
        new_hi = up[63:32]; new_lo = up[31:0]; cycles = 5;
      end
      OP_DIV: begin
        cycles = 10;
        if (rt != 0) begin
          sa = longint'($signed(rs));
          sb = longint'($signed(rt));
          q = sa / sb;
          r = sa % sb;
          new_lo = q[31:0]; new_hi = r[31:0];
        end
      end
      OP_DIVU: begin
        cycles = 10;
        if (rt != 0) begin
          new_lo = rs / rt; new_hi = rs % rt;
        end
      end
      OP_MTHI: new_hi = rs;
      OP_MTLO: new_lo = rs;
      default: ;
    endcase
  endtask

  // Start an op, count busy cycles (bounded), then check final state.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int exp_cycles,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    @(negedge clk);
    md_op = op; rs_val = rs; rt_val = rt;
    #1;
    check({name, " hazard_start"}, {31'd0, md_hazard}, 32'd1);
    @(negedge clk);
    md_op = OP_NONE;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (md_hazard !== 1'b1) check({name, " hazard_busy"}, {31'd0, md_hazard}, 32'd1);
      n++;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, n, exp_cycles);
    check({name, " hi"}, hi, exp_hi);
    check({name, " lo"}, lo, exp_lo);
    check({name, " hazard_end"}, {31'd0, md_hazard}, 32'd0);
  endtask

  task automatic move(input logic [2:0] op, input logic [31:0] v);
    @(negedge clk);
    md_op = op; rs_val = v;
    @(negedge clk);
    md_op = OP_NONE;
  endtask

  vec_t vecs[6];

  initial begin
    logic [31:0] m_hi, m_lo, e_hi, e_lo;
    logic [2:0]  op;
    logic [31:0] rs, rt;
    int          cyc;

    vecs[0] = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{OP_DIVU,  32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003};
    vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[5] = '{OP_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};

    reset = 1'b1; md_op = OP_NONE; rs_val = 0; rt_val = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", {31'd0, busy}, 0);
    check("reset hazard", {31'd0, md_hazard}, 0);

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].cycles,
             vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // Divide by zero leaves preloaded HI/LO untouched.
    move(OP_MTHI, 32'h1111);
    move(OP_MTLO, 32'h2222);
    check("preload hi", hi, 32'h1111);
    check("preload lo", lo, 32'h2222);
    run_op("div0", OP_DIV, 32'h1234, 32'd0, 10, 32'h1111, 32'h2222);

    // MTHI during busy cycle 2 of a MULT is ignored.
    @(negedge clk);
    md_op = OP_MULT; rs_val = 32'd3; rt_val = 32'd4;
    @(negedge clk);
    md_op = OP_NONE;
    @(negedge clk);
    md_op = OP_MTHI; rs_val = 32'h1234;
    @(negedge clk);
    md_op = OP_NONE;
    repeat (4) @(negedge clk);
    check("mthi_busy busy", {31'd0, busy}, 0);
    check("mthi_busy hi", hi, 32'd0);
    check("mthi_busy lo", lo, 32'd12);

    // MTHI while idle.
    move(OP_MTHI, 32'h1234);
    check("mthi hi", hi, 32'h1234);
    check("mthi lo", lo, 32'd12);

    // Reset in busy cycle 3 of a DIV: no late commit.
    @(negedge clk);
    md_op = OP_DIVU; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    md_op = OP_NONE;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid busy", {31'd0, busy}, 0);
    check("rst_mid hi", hi, 0);
    check("rst_mid lo", lo, 0);
    check("rst_mid hazard", {31'd0, md_hazard}, 0);
    repeat (12) @(negedge clk);
    check("rst_late hi", hi, 0);
    check("rst_late lo", lo, 0);

    // Random ops checked against the model.
    m_hi = hi; m_lo = lo;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 6));
      rs = $urandom;
      rt = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rt = rt & 32'hFF;
      model(op, rs, rt, m_hi, m_lo, e_hi, e_lo, cyc);
      if (op == OP_MTHI || op == OP_MTLO) begin
        move(op, rs);
        check($sformatf("rnd%0d hi", i), hi, e_hi);
        check($sformatf("rnd%0d lo", i), lo, e_lo);
      end else begin
        run_op($sformatf("rnd%0d", i), op, rs, rt, cyc, e_hi, e_lo);
      end
      m_hi = e_hi; m_lo = e_lo;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
